// File: rtl/bcd_counter_8digit.sv
// Eight-digit packed-BCD up/down counter stepped by an internal prescaler tick.
// The stepped value, tick and wrap flags are registered together on the step edge.
module bcd_counter_8digit #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        up,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] bcd,
  output logic        tick,
  output logic        wrap
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          step;
  logic [31:0]   load_sat;
  logic [31:0]   step_value;
  logic          step_wrap;
  logic          chain_carry;
  logic [3:0]    chain_digit;
  logic [3:0]    load_digit;

  assign step = enable && (presc == PRESC_LAST);

  // Out-of-range nibbles on a load are clamped to 9 so bcd always holds valid digits.
  always_comb begin
    load_sat   = '0;
    load_digit = '0;
    for (int i = 0; i < 8; i++) begin
      load_digit          = load_value[4*i +: 4];
      load_sat[4*i +: 4]  = (load_digit > 4'd9) ? 4'd9 : load_digit;
    end
  end

  // Ripple carry/borrow: a carry surviving past digit 7 means the count wrapped.
  always_comb begin
    step_value  = bcd;
    chain_carry = 1'b1;
    chain_digit = '0;
    for (int i = 0; i < 8; i++) begin
      chain_digit = bcd[4*i +: 4];
      if (chain_carry) begin
        if (up) begin
          if (chain_digit == 4'd9) begin
            chain_digit = 4'd0;
          end else begin
            chain_digit = chain_digit + 4'd1;
            chain_carry = 1'b0;
          end
        end else begin
          if (chain_digit == 4'd0) begin
            chain_digit = 4'd9;
          end else begin
            chain_digit = chain_digit - 4'd1;
            chain_carry = 1'b0;
          end
        end
      end
      step_value[4*i +: 4] = chain_digit;
    end
    step_wrap = chain_carry;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      bcd   <= '0;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      bcd   <= load_sat;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= step;
      wrap <= step && step_wrap;
      if (step) begin
        presc <= '0;
        bcd   <= step_value;
      end else if (enable) begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: doc/bcd_counter_8digit.md
# bcd_counter_8digit

Eight-digit BCD up/down counter with a built-in prescaler, the upstream stage that produces the packed BCD value consumed by the 8-display BCD-to-7-segment driver. A free-running prescaler on the board clock generates a periodic update tick (1 Hz by default at 50 MHz). On each tick the counter steps by one in decimal across all eight digits, wrapping at the range ends. Synchronous clear and parallel load are provided for board control and for verification.

## Interface

- CLK_FREQ_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count update rate in Hz.
- DIV (localparam) = CLK_FREQ_HZ / TICK_HZ, clock cycles per tick; must be ≥ 2. The prescaler width is ceil(log2(DIV)).

- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = prescaler runs and the counter steps on ticks; 0 = prescaler and count freeze.
- up  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clear  input  1  synchronous clear of the count and prescaler.
- load  input  1  synchronous parallel load of load_value.
- load_value  input  32  eight BCD nibbles; digit 0 (least significant) in [3:0], digit 7 in [31:28].
- bcd  output  32  current count, packed the same way as load_value.
- tick  output  1  one-cycle pulse, high in the first cycle in which bcd shows a tick-stepped value.
- wrap  output  1  one-cycle pulse coincident with tick when the step wrapped: 99999999→0 up, or 0→99999999 down.

## Operation

- Priority per edge: reset > clear > load > tick step.
- reset: bcd = 0, prescaler = 0, tick = 0, wrap = 0.
- clear: bcd = 0, prescaler = 0, tick = 0, wrap = 0. Acts regardless of enable.
- load: bcd takes load_value, prescaler = 0, tick = 0, wrap = 0. Any nibble > 9 is stored as 9. Acts regardless of enable.
- Prescaler: when enable = 1 and no reset/clear/load, it counts 0..DIV-1. At DIV-1 it returns to 0 and a step occurs on the same edge. When enable = 0, it holds its value and does not reset, so partial periods resume.
- Step up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. If all digits are 9, the result is 0 and wrap = 1.
- Step down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. If all digits are 0, the result is 99999999 and wrap = 1.
- Carry/borrow chain is combinational across all 8 digits within one cycle. The result is registered on the step edge.
- tick and wrap are registered. They are high for exactly one cycle after a step edge and 0 otherwise.
- A change of up between ticks has no effect until the next step.

## Timing

- Latency: from reset release with enable = 1, the first step edge is the DIV-th rising edge. bcd and tick update together on that edge and are visible for the following cycle.
- Tick period is exactly DIV cycles while enable stays 1. tick is never asserted in consecutive cycles because DIV ≥ 2.
- enable low for N cycles delays the next tick by exactly N cycles.
- After load or clear, the next tick comes DIV enabled cycles later.
- Reset or clear asserted in the same cycle as a step edge: the step is discarded and tick stays 0.
- Load in the same cycle as a step edge: the loaded value wins and no tick is issued.

## Test plan

- DIV = 10, reset, then enable = 1, up = 1 → tick at cycle 10 with bcd = 0x00000001. After 10 ticks, bcd = 0x00000010, and tick spacing is exactly 10 cycles.
- Load 0x99999999, up = 1 → next tick gives bcd = 0x00000000 with wrap = 1 in the same cycle as tick. Load 0x00000000, up = 0 → next tick gives 0x99999999 with wrap = 1.
- Load 0x00001000, up = 0 → 0x00000999, wrap = 0. Load 0x0000009F → bcd = 0x00000099, then up-tick gives 0x00000100.
- Drop enable for 7 cycles mid-period (after 4 prescaler counts) → next tick occurs 17 cycles after the previous tick, and bcd is unchanged while enable = 0.
- Assert clear and load (0x12345678) in the same cycle → bcd = 0. Assert load on a step edge → bcd = 0x12345678 with tick = 0.
- Reset mid-count at bcd = 0x00000042 → bcd = 0, tick = 0, wrap = 0 on the next cycle, and the first tick comes DIV cycles after reset deasserts.
